// File: rtl/cabin_light_pkg.sv
// rtl/cabin_light_pkg.sv - shared state encoding and per-mode brightness targets for cabin_light_ctrl
//
// Contents:
//   light_state_t   per-zone FSM state, same 2-bit encoding as the zone_mode request
//   MODE_*          raw mode request encodings
//   target_level()  brightness target for a state, given MAX and the dimming level
package cabin_light_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    NORMAL    = 2'b01,
    DIMMING   = 2'b10,
    EMERGENCY = 2'b11
  } light_state_t;

  localparam logic [1:0] MODE_IDLE      = 2'b00;
  localparam logic [1:0] MODE_NORMAL    = 2'b01;
  localparam logic [1:0] MODE_DIMMING   = 2'b10;
  localparam logic [1:0] MODE_EMERGENCY = 2'b11;

  // EMERGENCY sits at full brightness; the flash is applied to led, not to brightness.
  function automatic int unsigned target_level(light_state_t state,
                                               int unsigned  max_level,
                                               int unsigned  dim_level);
    case (state)
      IDLE:    return 0;
      NORMAL:  return max_level;
      DIMMING: return dim_level;
      default: return max_level;
    endcase
  endfunction

endpackage

// File: rtl/cabin_light_zone.sv
// rtl/cabin_light_zone.sv - one lighting zone: mode FSM, brightness ramp and LED drive register
//
// Build option: LIGHT_SOFT_RAMP_EN (defined: step 1 per ramp_tick; undefined: load target on tick)
// Ports:
//   clk, reset      clock, async active-high reset
//   mode            requested mode for this zone
//   emergency_req   global override, forces EMERGENCY
//   ramp_tick       shared ramp step strobe
//   flash_on        flash phase the LED takes on this edge while in EMERGENCY
//   pwm_cnt         shared free-running PWM counter
//   state           registered FSM state
//   brightness      registered brightness level
//   led             registered LED drive
//   emerg_next      combinational: zone enters/stays in EMERGENCY on the coming edge
module cabin_light_zone
  import cabin_light_pkg::*;
#(
  parameter int unsigned PWM_W     = 8,
  parameter int unsigned DIM_LEVEL = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       mode,
  input  logic             emergency_req,
  input  logic             ramp_tick,
  input  logic             flash_on,
  input  logic [PWM_W-1:0] pwm_cnt,
  output light_state_t     state,
  output logic [PWM_W-1:0] brightness,
  output logic             led,
  output logic             emerg_next
);

  localparam int unsigned      MAX_LEVEL = (1 << PWM_W) - 1;
  localparam logic [PWM_W-1:0] MAX       = '1;

  light_state_t     next_state;
  logic [PWM_W-1:0] target;

  always_comb begin
    next_state = emergency_req ? EMERGENCY : light_state_t'(mode);
    // The ramp chases the target of the state already registered, so a
    // request shows up on zone_state one edge before brightness starts moving.
    target     = PWM_W'(target_level(state, MAX_LEVEL, DIM_LEVEL));
    emerg_next = (next_state == EMERGENCY);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      brightness <= '0;
      led        <= 1'b0;
    end else begin
      state <= next_state;

      // Entry into EMERGENCY jumps to full brightness and beats any ramp step.
      if (emerg_next && (state != EMERGENCY)) begin
        brightness <= MAX;
      end else if (ramp_tick) begin
`ifdef LIGHT_SOFT_RAMP_EN
        if (brightness < target) begin
          brightness <= brightness + PWM_W'(1);
        end else if (brightness > target) begin
          brightness <= brightness - PWM_W'(1);
        end
`else
        brightness <= target;
`endif
      end

      if (emerg_next) begin
        led <= flash_on;
      end else begin
        led <= (brightness == MAX) || (pwm_cnt < brightness);
      end
    end
  end

endmodule

// File: rtl/cabin_light_ctrl.sv
// rtl/cabin_light_ctrl.sv - multi-zone cabin lighting controller with ramped PWM and emergency flash
//
// Build option: LIGHT_SOFT_RAMP_EN (defined: brightness ramps 1 step per RAMP_DIV cycles;
//               undefined: brightness loads its target one edge after the state change)
// Ports:
//   clk               system clock, rising edge
//   reset             async active-high, clears all state
//   zone_mode         per-zone mode request, zone i at [2i+1:2i]
//   emergency_req     forces every zone to EMERGENCY while high
//   led               registered LED drive, one bit per zone
//   zone_state        registered per-zone state, zone i at [2i+1:2i]
//   brightness        registered per-zone brightness, zone i at [PWM_W*i +: PWM_W]
//   emergency_active  registered, high while any zone is in EMERGENCY
module cabin_light_ctrl
  import cabin_light_pkg::*;
#(
  parameter int unsigned NUM_ZONES  = 4,
  parameter int unsigned PWM_W      = 8,
  parameter int unsigned DIM_LEVEL  = 64,
  parameter int unsigned RAMP_DIV   = 16,
  parameter int unsigned FLASH_HALF = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [2*NUM_ZONES-1:0]     zone_mode,
  input  logic                       emergency_req,
  output logic [NUM_ZONES-1:0]       led,
  output logic [2*NUM_ZONES-1:0]     zone_state,
  output logic [PWM_W*NUM_ZONES-1:0] brightness,
  output logic                       emergency_active
);

`ifdef LIGHT_SOFT_RAMP_EN
  localparam int unsigned TICK_DIV = RAMP_DIV;
`else
  // Without the soft ramp every cycle is a tick, so the target loads directly.
  localparam int unsigned TICK_DIV = 1 + 0 * RAMP_DIV;
`endif
  localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned FL_W  = $clog2(2 * FLASH_HALF);

  logic [PWM_W-1:0]     pwm_cnt;
  logic [PRE_W-1:0]     presc;
  logic                 ramp_tick;
  logic [FL_W-1:0]      flash_cnt;
  logic [FL_W-1:0]      flash_next;
  logic                 flash_on;
  logic [NUM_ZONES-1:0] zone_emerg_next;
  logic                 any_emerg_next;
  logic                 entering;
  light_state_t         zone_st [NUM_ZONES];

  always_comb begin
    ramp_tick      = (presc == PRE_W'(TICK_DIV - 1));
    any_emerg_next = |zone_emerg_next;
    entering       = any_emerg_next && !emergency_active;
    // The flash counter restarts on the edge emergency goes active, and the
    // LED registers sample the phase the counter is about to hold, so the
    // first FLASH_HALF cycles of an emergency are always lit.
    if (entering || (flash_cnt == FL_W'(2 * FLASH_HALF - 1))) begin
      flash_next = '0;
    end else begin
      flash_next = flash_cnt + FL_W'(1);
    end
    flash_on = (flash_next < FL_W'(FLASH_HALF));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwm_cnt          <= '0;
      presc            <= '0;
      flash_cnt        <= '0;
      emergency_active <= 1'b0;
    end else begin
      pwm_cnt          <= pwm_cnt + PWM_W'(1);
      presc            <= ramp_tick ? '0 : presc + PRE_W'(1);
      flash_cnt        <= flash_next;
      emergency_active <= any_emerg_next;
    end
  end

  for (genvar i = 0; i < NUM_ZONES; i++) begin : g_zone
    cabin_light_zone #(
      .PWM_W    (PWM_W),
      .DIM_LEVEL(DIM_LEVEL)
    ) u_zone (
      .clk          (clk),
      .reset        (reset),
      .mode         (zone_mode[2*i +: 2]),
      .emergency_req(emergency_req),
      .ramp_tick    (ramp_tick),
      .flash_on     (flash_on),
      .pwm_cnt      (pwm_cnt),
      .state        (zone_st[i]),
      .brightness   (brightness[PWM_W*i +: PWM_W]),
      .led          (led[i]),
      .emerg_next   (zone_emerg_next[i])
    );
    assign zone_state[2*i +: 2] = zone_st[i];
  end

endmodule
